// File: rtl/weight_buffer_pkg.sv
// weight_buffer_pkg
//   Shared sizing for the weight/bias line buffers: default geometry,
//   address-width and read-word-width helpers, and the bank slice offset
//   helper used to place bank b inside a full read word.
//   Shared with the control unit and the weight-buffer control interface.
package weight_buffer_pkg;

   localparam int unsigned WEIGHT_BANK_BIT_WIDTH_DEF         = 64;
   localparam int unsigned WEIGHT_BUFFER_BANK_COUNT_DEF      = 8;
   localparam int unsigned WEIGHT_LINE_BUFFER_DEPTH_DEF      = 512;
   localparam int unsigned NUMBER_OF_WEIGHT_LINE_BUFFERS_DEF = 6;
   localparam int unsigned BIAS_LINE_BUFFER_DEPTH_DEF        = 32;
   localparam int unsigned BIAS_BUFFER_BANK_COUNT_DEF        = 4;
   localparam int unsigned BIAS_BANK_BIT_WIDTH_DEF           = 64;

   // Address width for a given depth; a depth of 1 still gets a 1-bit address.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of one full read word (all banks side by side).
   function automatic int unsigned read_word_width(input int unsigned bank_bit_width,
                                                   input int unsigned bank_count);
      return bank_bit_width * bank_count;
   endfunction

   // LSB position of bank b inside a read word.
   function automatic int unsigned bank_lsb(input int unsigned bank,
                                            input int unsigned bank_bit_width);
      return bank * bank_bit_width;
   endfunction

   localparam int unsigned WA = addr_width(WEIGHT_LINE_BUFFER_DEPTH_DEF);
   localparam int unsigned BA = addr_width(BIAS_LINE_BUFFER_DEPTH_DEF);

endpackage

// File: rtl/weight_line_buffer.sv
// weight_line_buffer
//   One line buffer: BANK_COUNT side-by-side memories of DEPTH words each,
//   one write port (word broadcast to every bank selected by write_wen) and
//   one read port returning all banks with 1-cycle latency, read-first.
//   Out-of-range addresses (only possible with non-power-of-two DEPTH) drop
//   the write and return 0 on the read.
// Ports
//   clk, reset     clock, asynchronous active-high reset (clears read register)
//   write_enable   write strobe
//   write_data     word written to each selected bank
//   write_wen      per-bank write select
//   write_addr     write word address
//   read_addr      read word address, sampled every edge
//   read_data      registered read word, bank b at [b*BANK_BIT_WIDTH +: BANK_BIT_WIDTH]
module weight_line_buffer
   import weight_buffer_pkg::*;
#(
   parameter  int unsigned BANK_BIT_WIDTH = 64,
   parameter  int unsigned BANK_COUNT     = 8,
   parameter  int unsigned DEPTH          = 512,
   localparam int unsigned AW             = addr_width(DEPTH),
   localparam int unsigned RW             = read_word_width(BANK_BIT_WIDTH, BANK_COUNT)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_enable,
   input  logic [BANK_BIT_WIDTH-1:0] write_data,
   input  logic [BANK_COUNT-1:0]     write_wen,
   input  logic [AW-1:0]             write_addr,
   input  logic [AW-1:0]             read_addr,
   output logic [RW-1:0]             read_data
);

   logic write_in_range;
   logic read_in_range;
   logic write_ok;

   // Extra bit on the compare so a power-of-two DEPTH does not truncate to 0.
   always_comb begin
      write_in_range = ({1'b0, write_addr} < (AW+1)'(DEPTH));
      read_in_range  = ({1'b0, read_addr}  < (AW+1)'(DEPTH));
      write_ok       = write_enable && write_in_range && !reset;
   end

   for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      logic [BANK_BIT_WIDTH-1:0] mem [DEPTH];
      logic [BANK_BIT_WIDTH-1:0] rd_q;

      // Memory has no reset so it maps onto block RAM.
      always_ff @(posedge clk) begin
         if (write_ok && write_wen[b]) begin
            mem[write_addr] <= write_data;
         end
      end

      // Read-first: the register samples the stored word before this edge's write lands.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rd_q <= '0;
         end else if (read_in_range) begin
            rd_q <= mem[read_addr];
         end else begin
            rd_q <= '0;
         end
      end

      assign read_data[bank_lsb(b, BANK_BIT_WIDTH) +: BANK_BIT_WIDTH] = rd_q;
   end

endmodule

// File: rtl/weight_buffer_memory_array.sv
// weight_buffer_memory_array
//   Slave-side storage behind the control unit: NUMBER_OF_WEIGHT_LINE_BUFFERS
//   independent weight line buffers plus one bias line buffer, all built from
//   weight_line_buffer. Feeds the MAC array weight/bias operand inputs.
// Ports (N = NUMBER_OF_WEIGHT_LINE_BUFFERS)
//   clk, reset                 clock, asynchronous active-high reset
//   write_port_*[N]            per weight buffer: enable, data, bank select, address
//   read_port_addr[N]          per weight buffer read address
//   read_port_data_out[N]      per weight buffer registered read word
//   bias_write_port_*          bias buffer write port
//   bias_read_port_addr        bias read address
//   bias_read_port_data_out    bias registered read word
module weight_buffer_memory_array
   import weight_buffer_pkg::*;
#(
   parameter  int unsigned WEIGHT_BANK_BIT_WIDTH         = WEIGHT_BANK_BIT_WIDTH_DEF,
   parameter  int unsigned WEIGHT_BUFFER_BANK_COUNT      = WEIGHT_BUFFER_BANK_COUNT_DEF,
   parameter  int unsigned WEIGHT_LINE_BUFFER_DEPTH      = WEIGHT_LINE_BUFFER_DEPTH_DEF,
   parameter  int unsigned NUMBER_OF_WEIGHT_LINE_BUFFERS = NUMBER_OF_WEIGHT_LINE_BUFFERS_DEF,
   parameter  int unsigned BIAS_LINE_BUFFER_DEPTH        = BIAS_LINE_BUFFER_DEPTH_DEF,
   parameter  int unsigned BIAS_BUFFER_BANK_COUNT        = BIAS_BUFFER_BANK_COUNT_DEF,
   parameter  int unsigned BIAS_BANK_BIT_WIDTH           = BIAS_BANK_BIT_WIDTH_DEF,
   localparam int unsigned N    = NUMBER_OF_WEIGHT_LINE_BUFFERS,
   localparam int unsigned WBW  = WEIGHT_BANK_BIT_WIDTH,
   localparam int unsigned WBC  = WEIGHT_BUFFER_BANK_COUNT,
   localparam int unsigned BBW  = BIAS_BANK_BIT_WIDTH,
   localparam int unsigned BBC  = BIAS_BUFFER_BANK_COUNT,
   localparam int unsigned WAW  = addr_width(WEIGHT_LINE_BUFFER_DEPTH),
   localparam int unsigned BAW  = addr_width(BIAS_LINE_BUFFER_DEPTH),
   localparam int unsigned WRW  = read_word_width(WBW, WBC),
   localparam int unsigned BRW  = read_word_width(BBW, BBC)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     write_port_enable,
   input  logic [WBW-1:0]   write_port_data_in  [N],
   input  logic [WBC-1:0]   write_port_wen      [N],
   input  logic [WAW-1:0]   write_port_addr     [N],
   input  logic [WAW-1:0]   read_port_addr      [N],
   output logic [WRW-1:0]   read_port_data_out  [N],
   input  logic             bias_write_port_enable,
   input  logic [BBW-1:0]   bias_write_port_data_in,
   input  logic [BBC-1:0]   bias_write_port_wen,
   input  logic [BAW-1:0]   bias_write_port_addr,
   input  logic [BAW-1:0]   bias_read_port_addr,
   output logic [BRW-1:0]   bias_read_port_data_out
);

   for (genvar i = 0; i < N; i++) begin : g_weight
      weight_line_buffer #(
         .BANK_BIT_WIDTH (WBW),
         .BANK_COUNT     (WBC),
         .DEPTH          (WEIGHT_LINE_BUFFER_DEPTH)
      ) u_weight_line_buffer (
         .clk          (clk),
         .reset        (reset),
         .write_enable (write_port_enable[i]),
         .write_data   (write_port_data_in[i]),
         .write_wen    (write_port_wen[i]),
         .write_addr   (write_port_addr[i]),
         .read_addr    (read_port_addr[i]),
         .read_data    (read_port_data_out[i])
      );
   end

   weight_line_buffer #(
      .BANK_BIT_WIDTH (BBW),
      .BANK_COUNT     (BBC),
      .DEPTH          (BIAS_LINE_BUFFER_DEPTH)
   ) u_bias_line_buffer (
      .clk          (clk),
      .reset        (reset),
      .write_enable (bias_write_port_enable),
      .write_data   (bias_write_port_data_in),
      .write_wen    (bias_write_port_wen),
      .write_addr   (bias_write_port_addr),
      .read_addr    (bias_read_port_addr),
      .read_data    (bias_read_port_data_out)
   );

endmodule

// File: tb/tb_weight_buffer_memory_array.sv
// tb_weight_buffer_memory_array
//   Randomized and directed checks of weight_buffer_memory_array against a
//   word-array reference model; a second instance built with depth 500
//   covers out-of-range addressing.
module tb_weight_buffer_memory_array;

   localparam int N   = 6;
   localparam int WBW = 64;
   localparam int WBC = 8;
   localparam int WD  = 512;
   localparam int BBC = 4;
   localparam int BD  = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // main DUT stimulus
   logic [N-1:0]     we;
   logic [WBW-1:0]   wd  [N];
   logic [WBC-1:0]   wen [N];
   logic [8:0]       wa  [N];
   logic [8:0]       ra  [N];
   logic [511:0]     rd  [N];
   logic             bwe;
   logic [63:0]      bwd;
   logic [3:0]       bwen;
   logic [4:0]       bwa;
   logic [4:0]       bra;
   logic [255:0]     brd;

   // depth-500 DUT stimulus
   logic [0:0]       d2_we;
   logic [63:0]      d2_wd  [1];
   logic [7:0]       d2_wen [1];
   logic [8:0]       d2_wa  [1];
   logic [8:0]       d2_ra  [1];
   logic [511:0]     d2_rd  [1];
   logic [255:0]     d2_brd;

   int tests  = 0;
   int failed = 0;

   // reference model: stored word per buffer / address / bank
   logic [63:0] m_w [N][WD][WBC];
   logic [63:0] m_b [BD][BBC];

   weight_buffer_memory_array dut (
      .clk                     (clk),
      .reset                   (reset),
      .write_port_enable       (we),
      .write_port_data_in      (wd),
      .write_port_wen          (wen),
      .write_port_addr         (wa),
      .read_port_addr          (ra),
      .read_port_data_out      (rd),
      .bias_write_port_enable  (bwe),
      .bias_write_port_data_in (bwd),
      .bias_write_port_wen     (bwen),
      .bias_write_port_addr    (bwa),
      .bias_read_port_addr     (bra),
      .bias_read_port_data_out (brd)
   );

   weight_buffer_memory_array #(
      .WEIGHT_LINE_BUFFER_DEPTH      (500),
      .NUMBER_OF_WEIGHT_LINE_BUFFERS (1)
   ) dut_d500 (
      .clk                     (clk),
      .reset                   (reset),
      .write_port_enable       (d2_we),
      .write_port_data_in      (d2_wd),
      .write_port_wen          (d2_wen),
      .write_port_addr         (d2_wa),
      .read_port_addr          (d2_ra),
      .read_port_data_out      (d2_rd),
      .bias_write_port_enable  (1'b0),
      .bias_write_port_data_in (64'd0),
      .bias_write_port_wen     (4'd0),
      .bias_write_port_addr    (5'd0),
      .bias_read_port_addr     (5'd0),
      .bias_read_port_data_out (d2_brd)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      we   = '0;
      bwe  = 1'b0;
      bwd  = '0;
      bwen = '0;
      bwa  = '0;
      bra  = '0;
      for (int i = 0; i < N; i++) begin
         wd[i]  = '0;
         wen[i] = '0;
         wa[i]  = '0;
         ra[i]  = '0;
      end
   endtask

   // One clock: predict read-first outputs from the model, apply writes to
   // the model, advance one edge, then compare.
   task automatic cycle(input bit chk);
      logic [511:0] ew [N];
      logic [255:0] eb;
      for (int i = 0; i < N; i++)
         for (int b = 0; b < WBC; b++)
            ew[i][b*64 +: 64] = reset ? 64'd0 : m_w[i][ra[i]][b];
      for (int b = 0; b < BBC; b++)
         eb[b*64 +: 64] = reset ? 64'd0 : m_b[bra][b];
      if (!reset) begin
         for (int i = 0; i < N; i++)
            for (int b = 0; b < WBC; b++)
               if (we[i] && wen[i][b]) m_w[i][wa[i]][b] = wd[i];
         for (int b = 0; b < BBC; b++)
            if (bwe && bwen[b]) m_b[bwa][b] = bwd;
      end
      @(posedge clk);
      #1;
      if (chk) begin
         for (int i = 0; i < N; i++)
            check($sformatf("rd%0d", i), rd[i], ew[i]);
         check("bias", {256'd0, brd}, {256'd0, eb});
      end
   endtask

   task automatic d2_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [511:0] exp2;
      idle();
      d2_we = '0; d2_wd[0] = '0; d2_wen[0] = '0; d2_wa[0] = '0; d2_ra[0] = '0;

      // reset state
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) check($sformatf("rst_rd%0d", i), rd[i], '0);
      check("rst_bias", {256'd0, brd}, '0);
      check("rst_d500", d2_rd[0], '0);
      @(posedge clk);
      #1;
      check("rst_hold", rd[0], '0);
      reset = 1'b0;

      // fill every address so the model is fully defined
      for (int a = 0; a < WD; a++) begin
         for (int i = 0; i < N; i++) begin
            we[i]  = 1'b1;
            wen[i] = '1;
            wa[i]  = 9'(a);
            wd[i]  = {$urandom, $urandom};
         end
         bwe  = (a < BD);
         bwen = '1;
         bwa  = 5'(a);
         bwd  = {$urandom, $urandom};
         cycle(1'b0);
      end

      // full-word write then read
      idle();
      we[0] = 1'b1; wen[0] = '1; wa[0] = 9'd5; wd[0] = 64'hA5A5_0000_0000_0001;
      cycle(1'b1);
      idle(); ra[0] = 9'd5;
      cycle(1'b1);
      check("t1_full", rd[0], {8{64'hA5A5_0000_0000_0001}});

      // partial bank write, then enable=0 must not write
      idle(); we[3] = 1'b1; wen[3] = '1; wa[3] = 9'd10; wd[3] = '0;
      cycle(1'b1);
      idle(); we[3] = 1'b1; wen[3] = 8'h04; wa[3] = 9'd10; wd[3] = 64'hDEAD;
      cycle(1'b1);
      idle(); wen[3] = 8'hFF; wa[3] = 9'd10; wd[3] = 64'd1; ra[3] = 9'd10;
      cycle(1'b1);
      exp2 = '0;
      exp2[2*64 +: 64] = 64'hDEAD;
      check("t2_partial", rd[3], exp2);
      idle(); ra[3] = 9'd10;
      cycle(1'b1);
      check("t2_noen", rd[3], exp2);

      // read/write collision: read-first
      idle(); we[1] = 1'b1; wen[1] = '1; wa[1] = 9'd7; wd[1] = 64'd1;
      cycle(1'b1);
      idle(); we[1] = 1'b1; wen[1] = '1; wa[1] = 9'd7; wd[1] = 64'd2; ra[1] = 9'd7;
      cycle(1'b1);
      check("t3_old", rd[1], {8{64'd1}});
      idle(); ra[1] = 9'd7;
      cycle(1'b1);
      check("t3_new", rd[1], {8{64'd2}});

      // all buffers + bias written in one cycle at the top address
      idle();
      for (int i = 0; i < N; i++) begin
         we[i] = 1'b1; wen[i] = '1; wa[i] = 9'd511; wd[i] = 64'(i + 1);
      end
      bwe = 1'b1; bwen = 4'hF; bwa = 5'd31; bwd = 64'd9;
      cycle(1'b1);
      idle();
      for (int i = 0; i < N; i++) ra[i] = 9'd511;
      bra = 5'd31;
      cycle(1'b1);
      for (int i = 0; i < N; i++) check($sformatf("t4_buf%0d", i), rd[i], {8{64'(i + 1)}});
      check("t4_bias", {256'd0, brd}, {256'd0, {4{64'd9}}});
      idle();
      cycle(1'b1);

      // reset in the middle of a read stream
      idle(); we[2] = 1'b1; wen[2] = '1; wa[2] = 9'd5; wd[2] = 64'h5555_AAAA_0000_0005;
      cycle(1'b1);
      for (int k = 0; k < 4; k++) begin
         idle(); ra[2] = 9'($urandom_range(0, 511));
         cycle(1'b1);
      end
      reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) check($sformatf("t5_async%0d", i), rd[i], '0);
      idle(); we[2] = 1'b1; wen[2] = '1; wa[2] = 9'd5; wd[2] = 64'hBAD0_BAD0_BAD0_BAD0; ra[2] = 9'd5;
      cycle(1'b1);
      reset = 1'b0;
      idle(); ra[2] = 9'd5;
      cycle(1'b1);
      check("t5_after", rd[2], {8{64'h5555_AAAA_0000_0005}});

      // randomized traffic with frequent collisions
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            we[i]  = 1'($urandom_range(0, 1));
            wen[i] = 8'($urandom);
            wa[i]  = 9'($urandom_range(0, 511));
            wd[i]  = {$urandom, $urandom};
            ra[i]  = ($urandom_range(0, 3) == 0) ? wa[i] : 9'($urandom_range(0, 511));
         end
         bwe  = 1'($urandom_range(0, 1));
         bwen = 4'($urandom);
         bwa  = 5'($urandom_range(0, 31));
         bwd  = {$urandom, $urandom};
         bra  = ($urandom_range(0, 3) == 0) ? bwa : 5'($urandom_range(0, 31));
         cycle(1'b1);
      end
      idle();

      // depth-500 build: out-of-range write dropped, read returns 0
      d2_we = 1'b1; d2_wen[0] = '1; d2_wa[0] = 9'd499; d2_wd[0] = 64'h0499_0499_0499_0499;
      d2_step();
      d2_wa[0] = 9'd505; d2_wd[0] = 64'hFFFF_0505_FFFF_0505;
      d2_step();
      d2_we = 1'b0; d2_ra[0] = 9'd505;
      d2_step();
      check("t6_oor", d2_rd[0], '0);
      d2_ra[0] = 9'd499;
      d2_step();
      check("t6_499", d2_rd[0], {8{64'h0499_0499_0499_0499}});
      d2_ra[0] = 9'd511;
      d2_step();
      check("t6_oor511", d2_rd[0], '0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
